load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Memory-side consumer of the decoder's AddrMode. Executes byte, halfword and word loads and stores
//  over a word-addressed 32-bit memory bus with a req/ack handshake. Misaligned accesses that cross a
//  word boundary are split into two bus beats. Load data is returned sign- or zero-extended. Sits
//  between the ALU address output and the ResultSrc mux; busy stalls the pipeline.
// PARAMETERS
//  DATA_WIDTH        32  datapath/bus data width (only 32 supported)
//  ADDR_WIDTH        32  byte address width
//  ALLOW_MISALIGNED  1   1: split crossing accesses into two beats; 0: flag error, no bus beat
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  req_valid  in   1   pipeline presents an access
//  req_ready  out  1   LSU idle; accepts the request this cycle
//  addr_mode  in   3   000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu, 101 sb, 110 sh, 111 sw
//  addr       in   32  byte address (ALU result)
//  wdata      in   32  store data (rs2), right-aligned
//  rsp_valid  out  1   one-cycle pulse: load data valid / store complete
//  rsp_err    out  1   qualifies rsp_valid: misaligned access rejected
//  rdata      out  32  extended load result (0 for stores and errors)
//  busy       out  1   ~req_ready; pipeline stall
//  bus_req    out  1   bus beat request, held until bus_ack
//  bus_we     out  1   1 = write beat
//  bus_addr   out  32  word-aligned address ([1:0]=00)
//  bus_be     out  4   byte lanes of this beat
//  bus_wdata  out  32  lane-aligned write data
//  bus_ack    in   1   beat complete; bus_rdata is valid in the same cycle
//  bus_rdata  in   32  read word
// BEHAVIOUR
//  FSM IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE.
//  - Reset: state = IDLE; bus_req, rsp_valid, rsp_err = 0; rdata, bus_* = 0; req_ready = 1.
//  - IDLE: req_ready = 1. On req_valid, latch mode/addr/wdata.
//    - Compute off = addr[1:0], size = 1/2/4, split = (off + size > 4).
//    - If split and ALLOW_MISALIGNED = 0: go to RESP with the error flagged. Otherwise go to ACC0.
//  - ACC0: bus_req = 1; bus_addr = {addr[31:2], 00}.
//    - bus_be = (size mask << off)[3:0]; bus_wdata = wdata << 8*off.
//    - All bus outputs held stable until bus_ack.
//    - On ack: capture bus_rdata into lo; go to ACC1 if split, else RESP.
//  - ACC1: bus_req stays 1; bus_addr = ACC0 address + 4 (0xFFFFFFFC wraps to 0x00000000).
//    - bus_be = remaining low lanes; bus_wdata = wdata >> 8*(4 - off).
//    - On ack: capture into hi; go to RESP.
//  - RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
//    - Loads: rdata = extend(({hi, lo} >> 8*off)[size]); sign-extend lb/lh, zero-extend lbu/lhu.
//  - bus_we = 1 for modes 101-111 only. Load beats also drive bus_be.
//  - Latency from the accepting edge to rsp_valid, with ack in the first request cycle:
//    2 cycles aligned, 3 cycles split, 1 cycle error. Each ack wait cycle adds 1.
//  - While state != IDLE, req_valid is ignored; the pipeline holds its request.
//  - bus_ack outside ACC0/ACC1 is ignored.
//  - Reset mid-access:
//    - The transaction is abandoned with no rsp_valid.
//    - bus_req is 0 in the cycle after the reset edge.
//    - A late ack is ignored.
// TESTING
//  1. lw 0x100, ack immediate, bus_rdata 0xDEADBEEF
//     -> bus_addr 0x100, be 1111, we 0; rsp_valid 2 cycles after accept; rdata 0xDEADBEEF.
//  2. lb 0x103, word 0x80FF0000 -> be 1000, rdata 0xFFFFFF80.
//     lbu at the same address -> rdata 0x00000080.
//  3. sh 0x203, wdata 0xABCD
//     -> beat0: 0x200, be 1000, wdata[31:24] = 0xCD.
//     -> beat1: 0x204, be 0001, wdata[7:0] = 0xAB.
//     -> rsp_valid after the 2nd ack.
//  4. lw 0x102, mem[0x100] = 0x44332211, mem[0x104] = 0x88776655 -> rdata 0x66554433.
//     lw 0xFFFFFFFE -> second beat at 0x00000000.
//  5. ack delayed 5 cycles
//     -> bus outputs stable, req_ready 0; a second req_valid is ignored; rsp after ack + 1.
//  6. rst during ACC1 -> bus_req 0 next cycle, no rsp_valid, req_ready 1.
//     ALLOW_MISALIGNED = 0, lh 0x103 -> no bus_req; rsp_valid and rsp_err 1 cycle after accept.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and memory-bus signals shared between the pipeline,
// the load/store unit and the word-addressed memory port.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic [2:0]              addr_mode;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rsp_valid;
  logic                    rsp_err;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    busy;
  logic                    bus_req;
  logic                    bus_we;
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic [DATA_WIDTH/8-1:0] bus_be;
  logic [DATA_WIDTH-1:0]   bus_wdata;
  logic                    bus_ack;
  logic [DATA_WIDTH-1:0]   bus_rdata;

  // The LSU itself: consumes pipeline requests and bus acks.
  modport slave (
    input  req_valid, addr_mode, addr, wdata, bus_ack, bus_rdata,
    output req_ready, rsp_valid, rsp_err, rdata, busy,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  // The environment: pipeline issuing accesses plus the memory answering beats.
  modport master (
    output req_valid, addr_mode, addr, wdata, bus_ack, bus_rdata,
    input  req_ready, rsp_valid, rsp_err, rdata, busy,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses over a word-addressed 32-bit bus
// with req/ack beats. Accesses crossing a word boundary take two beats (or are
// rejected when misalignment is disallowed). Loads return sign/zero-extended data.
module load_store_unit #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave lsu_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [2:0]            mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] lo_q, hi_q;
  logic                  split_q;
  logic                  err_q;

  // Access size in bytes for each addressing mode.
  function automatic logic [2:0] size_of(input logic [2:0] mode);
    case (mode)
      3'b000, 3'b011, 3'b101: size_of = 3'd1;
      3'b001, 3'b100, 3'b110: size_of = 3'd2;
      default:                size_of = 3'd4;
    endcase
  endfunction

  logic [2:0] req_size;
  logic       req_split;
  logic       accept;

  // Decode the incoming request: does it spill into the next word?
  always_comb begin
    req_size  = size_of(lsu_if.addr_mode);
    req_split = ({2'b00, lsu_if.addr[1:0]} + {1'b0, req_size}) > 4'd4;
  end

  assign accept = (state_q == S_IDLE) && lsu_if.req_valid;

  // Next-state logic: acks only matter while a beat is outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (lsu_if.req_valid)
                state_d = (req_split && !ALLOW_MISALIGNED) ? S_RESP : S_ACC0;
      S_ACC0: if (lsu_if.bus_ack) state_d = split_q ? S_ACC1 : S_RESP;
      S_ACC1: if (lsu_if.bus_ack) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request latch and read-beat capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        mode_q  <= lsu_if.addr_mode;
        addr_q  <= lsu_if.addr;
        wdata_q <= lsu_if.wdata;
        split_q <= req_split;
        err_q   <= req_split && !ALLOW_MISALIGNED;
        lo_q    <= '0;
        hi_q    <= '0;
      end
      if (state_q == S_ACC0 && lsu_if.bus_ack) lo_q <= lsu_if.bus_rdata;
      if (state_q == S_ACC1 && lsu_if.bus_ack) hi_q <= lsu_if.bus_rdata;
    end
  end

  // Everything driven onto the bus derives from latched request state, so it
  // stays stable for as long as a beat waits for its ack.
  logic [2:0]              size_q;
  logic [1:0]              off_q;
  logic [4:0]              shamt;
  logic                    is_store;
  logic [3:0]              size_mask;
  logic [7:0]              lane_span;
  logic [2*DATA_WIDTH-1:0] wdata_span;
  logic [DATA_WIDTH-1:0]   window;
  logic [DATA_WIDTH-1:0]   load_val;
  logic [ADDR_WIDTH-1:0]   word_addr;

  assign size_q    = size_of(mode_q);
  assign off_q     = addr_q[1:0];
  assign shamt     = {off_q, 3'b000};
  assign is_store  = (mode_q >= 3'b101);
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  // One enable bit per byte of the access, before placement on the lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_size_mask
      assign size_mask[gi] = (3'(gi) < size_q);
    end
  endgenerate

  // Two-word view: the low half feeds the first beat, the high half the second.
  assign lane_span  = {4'b0000, size_mask} << off_q;
  assign wdata_span = {{DATA_WIDTH{1'b0}}, wdata_q} << shamt;
  assign window     = DATA_WIDTH'({hi_q, lo_q} >> shamt);

  // Extend the selected bytes according to the load flavour.
  always_comb begin
    case (mode_q)
      3'b000:  load_val = {{24{window[7]}}, window[7:0]};
      3'b011:  load_val = {24'b0, window[7:0]};
      3'b001:  load_val = {{16{window[15]}}, window[15:0]};
      3'b100:  load_val = {16'b0, window[15:0]};
      default: load_val = window;
    endcase
  end

  // Bus beat outputs; idle value is all zeros.
  always_comb begin
    lsu_if.bus_req   = 1'b0;
    lsu_if.bus_we    = 1'b0;
    lsu_if.bus_addr  = '0;
    lsu_if.bus_be    = '0;
    lsu_if.bus_wdata = '0;
    case (state_q)
      S_ACC0: begin
        lsu_if.bus_req   = 1'b1;
        lsu_if.bus_we    = is_store;
        lsu_if.bus_addr  = word_addr;
        lsu_if.bus_be    = lane_span[3:0];
        lsu_if.bus_wdata = wdata_span[DATA_WIDTH-1:0];
      end
      S_ACC1: begin
        lsu_if.bus_req   = 1'b1;
        lsu_if.bus_we    = is_store;
        lsu_if.bus_addr  = word_addr + ADDR_WIDTH'(4);
        lsu_if.bus_be    = lane_span[7:4];
        lsu_if.bus_wdata = wdata_span[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: ;
    endcase
  end

  // Pipeline-facing handshake and response.
  always_comb begin
    lsu_if.req_ready = (state_q == S_IDLE);
    lsu_if.busy      = (state_q != S_IDLE);
    lsu_if.rsp_valid = (state_q == S_RESP);
    lsu_if.rsp_err   = (state_q == S_RESP) && err_q;
    lsu_if.rdata     = (state_q == S_RESP && !is_store && !err_q) ? load_val : '0;
  end

endmodule
